// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encode/decode constants and the field-tuple payload type.
package inst_encoder_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned FMT_W    = 3;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;

  localparam logic [FMT_W-1:0] FMT_R = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J = 3'd5;

  localparam logic [OPCODE_W-1:0] OP     = 7'h33;
  localparam logic [OPCODE_W-1:0] OP_IMM = 7'h13;
  localparam logic [OPCODE_W-1:0] LUI    = 7'h37;
  localparam logic [OPCODE_W-1:0] STORE  = 7'h23;
  localparam logic [OPCODE_W-1:0] BRANCH = 7'h63;
  localparam logic [OPCODE_W-1:0] JAL    = 7'h6f;

  typedef struct packed {
    logic [FMT_W-1:0]    fmt;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [FUNCT3_W-1:0] funct3;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [FUNCT7_W-1:0] funct7;
    logic [INST_W-1:0]   imm;
  } inst_fields_t;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational fields-to-word packer; flags format codes with no RV32I layout.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  inst_fields_t        fields,
  output logic [INST_W-1:0]   word_c,
  output logic                illegal_c
);

  // Immediate bit scrambling mirrors the decode stage exactly; imm[0] is implicit for B/J.
  always_comb begin
    word_c    = '0;
    illegal_c = 1'b0;
    case (fields.fmt)
      FMT_R: word_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                       fields.rd, fields.opcode};
      FMT_I: word_c = {fields.imm[11:0], fields.rs1, fields.funct3,
                       fields.rd, fields.opcode};
      FMT_S: word_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                       fields.imm[4:0], fields.opcode};
      FMT_B: word_c = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                       fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
      FMT_U: word_c = {fields.imm[31:12], fields.rd, fields.opcode};
      FMT_J: word_c = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                       fields.imm[19:12], fields.rd, fields.opcode};
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: encodes RV32I field tuples and streams them into instruction memory.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FMT_W-1:0]    fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rd,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic [FUNCT7_W-1:0] funct7,
  input  logic [INST_W-1:0]   imm,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INST_W-1:0]   mem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                err
);

  localparam int unsigned       CNT_W      = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(RESET_ADDR);
  localparam logic [CNT_W-1:0]  CAPACITY   = CNT_W'(1) << ADDR_W;

  inst_fields_t        fields_c;
  logic [INST_W-1:0]   word_c;
  logic                illegal_c;
  logic                accept_c;
  logic                wr_done_c;

  logic                mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [INST_W-1:0]   mem_wdata_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                full_nxt;
  logic                err_nxt;

  assign fields_c = '{fmt: fmt, opcode: opcode, rd: rd, funct3: funct3,
                      rs1: rs1, rs2: rs2, funct7: funct7, imm: imm};

  inst_pack u_pack (
    .fields    (fields_c),
    .word_c    (word_c),
    .illegal_c (illegal_c)
  );

  // Pending word may be replaced in the same cycle it drains, giving 1 word/cycle.
  assign in_ready  = !full && !clear && (!mem_we || mem_ready);
  assign accept_c  = in_valid && in_ready;
  assign wr_done_c = mem_we && mem_ready;

  always_comb begin
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    count_nxt     = count;
    full_nxt      = full;
    err_nxt       = err;
    if (clear) begin
      mem_we_nxt   = 1'b0;
      mem_addr_nxt = START_ADDR;
      count_nxt    = '0;
      full_nxt     = 1'b0;
    end else begin
      if (wr_done_c) begin
        mem_we_nxt   = 1'b0;
        mem_addr_nxt = mem_addr + ADDR_W'(1);
        count_nxt    = count + CNT_W'(1);
        full_nxt     = (count + CNT_W'(1)) == CAPACITY;
      end
      if (accept_c) begin
        if (illegal_c) begin
          err_nxt = 1'b1;
        end else begin
          mem_we_nxt    = 1'b1;
          mem_wdata_nxt = word_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= START_ADDR;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      count     <= count_nxt;
      full      <= full_nxt;
      err       <= err_nxt;
    end
  end

endmodule
